// File: rtl/mucosmic_pkg.sv
// Shared definitions for the pulse trigger sequencer.
//   state_e    : sequencer state encoding, also driven out on state_o
//   evt_meta_t : event payload fields whose width does not depend on DATA_W
//   sat_inc    : saturating increment for the dropped-event counter
package mucosmic_pkg;
   localparam int TS_W    = 32;
   localparam int WIDTH_W = 16;
   localparam int DROP_W  = 16;
   localparam int STATE_W = 3;

   typedef enum logic [STATE_W-1:0] {
      S_IDLE    = 3'd0,
      S_SETTLE  = 3'd1,
      S_ARMED   = 3'd2,
      S_PULSE   = 3'd3,
      S_HOLDOFF = 3'd4
   } state_e;

   typedef struct packed {
      logic [TS_W-1:0]    ts;
      logic [WIDTH_W-1:0] width;
      logic               trunc;
   } evt_meta_t;

   function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
      return (v == '1) ? v : v + DROP_W'(1);
   endfunction
endpackage

// File: rtl/pulse_trigger_sequencer_if.sv
// Event output bus of the pulse trigger sequencer.
//   master : event source (evt_valid + payload out, evt_ready in)
//   slave  : event consumer
interface pulse_trigger_sequencer_if
   import mucosmic_pkg::*;
#(
   parameter int DATA_W = 14
);
   logic                     evt_valid;
   logic                     evt_ready;
   logic [TS_W-1:0]          evt_ts;
   logic signed [DATA_W-1:0] evt_peak;
   logic [WIDTH_W-1:0]       evt_width;
   logic                     evt_trunc;

   modport master (output evt_valid, evt_ts, evt_peak, evt_width, evt_trunc,
                   input  evt_ready);
   modport slave  (input  evt_valid, evt_ts, evt_peak, evt_width, evt_trunc,
                   output evt_ready);
endinterface

// File: rtl/evt_slot.sv
// Single-entry output event register with valid/ready handshake.
//   post_i/peak_i/meta_i : new event offered this cycle
//   ready_i              : consumer accepts the held event
//   valid_o/peak_o/meta_o: held event, stable until accepted
//   drop_cnt_o           : saturating count of events lost to a full slot
module evt_slot
   import mucosmic_pkg::*;
#(
   parameter int DATA_W = 14
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     post_i,
   input  logic signed [DATA_W-1:0] peak_i,
   input  evt_meta_t                meta_i,
   input  logic                     ready_i,
   output logic                     valid_o,
   output logic signed [DATA_W-1:0] peak_o,
   output evt_meta_t                meta_o,
   output logic [DROP_W-1:0]        drop_cnt_o
);
   logic                     valid_q;
   logic signed [DATA_W-1:0] peak_q;
   evt_meta_t                meta_q;
   logic [DROP_W-1:0]        drop_q;
   logic                     accept;

   assign accept = valid_q & ready_i;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= 1'b0;
         peak_q  <= '0;
         meta_q  <= '0;
         drop_q  <= '0;
      end else if (post_i && (!valid_q || accept)) begin
         // slot empty or being drained this very cycle: take the new event
         valid_q <= 1'b1;
         peak_q  <= peak_i;
         meta_q  <= meta_i;
      end else begin
         if (post_i) drop_q <= sat_inc(drop_q);
         if (accept) valid_q <= 1'b0;
      end
   end

   assign valid_o    = valid_q;
   assign peak_o     = peak_q;
   assign meta_o     = meta_q;
   assign drop_cnt_o = drop_q;
endmodule

// File: rtl/pulse_trigger_sequencer.sv
// Pulse trigger sequencer: settles the baseline filter after enable, then
// triggers on filtered samples crossing thr_rise, tracks peak/width until the
// sample falls below thr_fall (or width hits MAX_W), and posts one event per
// pulse into a single-entry output slot, followed by a holdoff dead time.
//   clk, rst             : clock, async active-high reset
//   enable, sample_valid : acquisition enable, new sample strobe
//   filt_in              : baseline-removed signed sample
//   thr_rise, thr_fall   : signed trigger / release thresholds
//   filt_rst             : holds baseline filter in reset (IDLE)
//   baseline_hold        : freezes baseline estimation (PULSE/HOLDOFF)
//   state_o, drop_cnt    : current state, dropped events
//   evt                  : event bus (master)
module pulse_trigger_sequencer
   import mucosmic_pkg::*;
#(
   parameter int DATA_W    = 14,
   parameter int SETTLE_N  = 1024,
   parameter int HOLDOFF_N = 16,
   parameter int MAX_W     = 4095
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     enable,
   input  logic                     sample_valid,
   input  logic signed [DATA_W-1:0] filt_in,
   input  logic signed [DATA_W-1:0] thr_rise,
   input  logic signed [DATA_W-1:0] thr_fall,
   output logic                     filt_rst,
   output logic                     baseline_hold,
   output logic [STATE_W-1:0]       state_o,
   output logic [DROP_W-1:0]        drop_cnt,
   pulse_trigger_sequencer_if.master evt
);
   state_e                   state_q;
   logic [31:0]              cnt_q;
   logic [TS_W-1:0]          ts_q, ts_cap_q;
   logic signed [DATA_W-1:0] peak_q, peak_d, evt_peak_d;
   logic [WIDTH_W-1:0]       width_q, width_d;
   logic                     filt_rst_q, hold_q;
   logic                     post_d;
   evt_meta_t                meta_d, slot_meta;

   // Pulse close decision for the current sample. A release sample is not
   // part of the pulse, so it reports the already-accumulated peak/width;
   // a truncating sample is included.
   always_comb begin
      peak_d     = (filt_in > peak_q) ? filt_in : peak_q;
      width_d    = width_q + WIDTH_W'(1);
      post_d     = 1'b0;
      evt_peak_d = peak_d;
      meta_d     = '{ts: ts_cap_q, width: width_d, trunc: 1'b0};
      if (enable && state_q == S_PULSE && sample_valid) begin
         if (filt_in < thr_fall) begin
            post_d       = 1'b1;
            evt_peak_d   = peak_q;
            meta_d.width = width_q;
         end else if (width_d == WIDTH_W'(MAX_W)) begin
            post_d       = 1'b1;
            meta_d.trunc = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         ts_q       <= '0;
         ts_cap_q   <= '0;
         peak_q     <= '0;
         width_q    <= '0;
         filt_rst_q <= 1'b1;
         hold_q     <= 1'b0;
      end else begin
         // timestamp runs from SETTLE entry; cleared while idle
         if (state_q == S_IDLE) ts_q <= '0;
         else if (enable)       ts_q <= ts_q + TS_W'(1);

         if (!enable) begin
            // an open pulse is silently abandoned here
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            filt_rst_q <= 1'b1;
            hold_q     <= 1'b0;
         end else begin
            case (state_q)
               S_IDLE: begin
                  state_q    <= S_SETTLE;
                  cnt_q      <= '0;
                  filt_rst_q <= 1'b0;
               end
               S_SETTLE: if (sample_valid) begin
                  if (cnt_q == 32'(SETTLE_N - 1)) begin
                     state_q <= S_ARMED;
                     cnt_q   <= '0;
                  end else cnt_q <= cnt_q + 32'd1;
               end
               S_ARMED: if (sample_valid && filt_in >= thr_rise) begin
                  state_q  <= S_PULSE;
                  hold_q   <= 1'b1;
                  peak_q   <= filt_in;
                  width_q  <= WIDTH_W'(1);
                  ts_cap_q <= ts_q;
               end
               S_PULSE: if (sample_valid) begin
                  if (post_d) begin
                     state_q <= S_HOLDOFF;
                     cnt_q   <= '0;
                  end else begin
                     peak_q  <= peak_d;
                     width_q <= width_d;
                  end
               end
               S_HOLDOFF: if (sample_valid) begin
                  if (cnt_q == 32'(HOLDOFF_N - 1)) begin
                     state_q <= S_ARMED;
                     cnt_q   <= '0;
                     hold_q  <= 1'b0;
                  end else cnt_q <= cnt_q + 32'd1;
               end
               default: begin
                  state_q    <= S_IDLE;
                  filt_rst_q <= 1'b1;
                  hold_q     <= 1'b0;
               end
            endcase
         end
      end
   end

   evt_slot #(.DATA_W(DATA_W)) u_slot (
      .clk        (clk),
      .rst        (rst),
      .post_i     (post_d),
      .peak_i     (evt_peak_d),
      .meta_i     (meta_d),
      .ready_i    (evt.evt_ready),
      .valid_o    (evt.evt_valid),
      .peak_o     (evt.evt_peak),
      .meta_o     (slot_meta),
      .drop_cnt_o (drop_cnt)
   );

   assign evt.evt_ts    = slot_meta.ts;
   assign evt.evt_width = slot_meta.width;
   assign evt.evt_trunc = slot_meta.trunc;

   assign filt_rst      = filt_rst_q;
   assign baseline_hold = hold_q;
   assign state_o       = state_q;
endmodule

// File: tb/tb_pulse_trigger_sequencer.sv
// Self-checking bench for pulse_trigger_sequencer: directed scenarios plus
// randomized sample streams checked against an array-scan event model.
module tb_pulse_trigger_sequencer;
   import mucosmic_pkg::*;

   localparam int DATA_W    = 14;
   localparam int SETTLE_N  = 4;
   localparam int HOLDOFF_N = 3;
   localparam int MAX_W     = 8;

   typedef struct {
      int ts;
      int peak;
      int width;
      bit trunc;
   } ev_t;

   logic                     clk = 1'b0;
   logic                     rst = 1'b1;
   logic                     enable = 1'b0;
   logic                     sample_valid = 1'b0;
   logic signed [DATA_W-1:0] filt_in = '0;
   logic signed [DATA_W-1:0] thr_rise = 14'sd100;
   logic signed [DATA_W-1:0] thr_fall = 14'sd50;
   logic                     filt_rst, baseline_hold;
   logic [2:0]               state_o;
   logic [15:0]              drop_cnt;
   int                       n_checks = 0;
   int                       n_fail = 0;
   int                       t = 0;

   pulse_trigger_sequencer_if #(.DATA_W(DATA_W)) eif();

   pulse_trigger_sequencer #(
      .DATA_W(DATA_W), .SETTLE_N(SETTLE_N), .HOLDOFF_N(HOLDOFF_N), .MAX_W(MAX_W)
   ) dut (
      .clk(clk), .rst(rst), .enable(enable), .sample_valid(sample_valid),
      .filt_in(filt_in), .thr_rise(thr_rise), .thr_fall(thr_fall),
      .filt_rst(filt_rst), .baseline_hold(baseline_hold),
      .state_o(state_o), .drop_cnt(drop_cnt), .evt(eif)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
      t++;
   endtask

   task automatic start_acq();
      enable = 1'b1;
      sample_valid = 1'b0;
      tick();
      t = 0;
   endtask

   task automatic feed(input int v);
      sample_valid = 1'b1;
      filt_in = DATA_W'(v);
      tick();
   endtask

   task automatic idle_cyc();
      sample_valid = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      rst = 1'b1; enable = 1'b0; sample_valid = 1'b0; eif.evt_ready = 1'b0;
      #12;
      n_checks++;
      if (state_o !== S_IDLE || filt_rst !== 1'b1 || baseline_hold !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_ctrl: state=%0d filt_rst=%b hold=%b, want 0/1/0", state_o, filt_rst, baseline_hold);
      end
      n_checks++;
      if (eif.evt_valid !== 1'b0 || drop_cnt !== 16'd0) begin
         n_fail++;
         $display("FAIL reset_evt: evt_valid=%b drop=%0d, want 0/0", eif.evt_valid, drop_cnt);
      end
      n_checks++;
      if (eif.evt_ts !== 32'd0 || eif.evt_peak !== 14'sd0 || eif.evt_width !== 16'd0 || eif.evt_trunc !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_payload: ts=%0d peak=%0d width=%0d trunc=%b, want zeros",
                  eif.evt_ts, eif.evt_peak, eif.evt_width, eif.evt_trunc);
      end
      @(negedge clk); rst = 1'b0;
      tick();
      n_checks++;
      if (state_o !== S_IDLE) begin
         n_fail++;
         $display("FAIL idle_hold: state=%0d, want %0d", state_o, S_IDLE);
      end
   endtask

   task automatic test_settle();
      start_acq();
      n_checks++;
      if (state_o !== S_SETTLE || filt_rst !== 1'b0 || baseline_hold !== 1'b0) begin
         n_fail++;
         $display("FAIL settle_entry: state=%0d filt_rst=%b hold=%b, want 1/0/0", state_o, filt_rst, baseline_hold);
      end
      feed(0); idle_cyc(); feed(0); idle_cyc(); idle_cyc(); feed(0);
      n_checks++;
      if (state_o !== S_SETTLE) begin
         n_fail++;
         $display("FAIL settle_3of4: state=%0d, want %0d", state_o, S_SETTLE);
      end
      feed(0);
      n_checks++;
      if (state_o !== S_ARMED) begin
         n_fail++;
         $display("FAIL settle_done: state=%0d, want %0d", state_o, S_ARMED);
      end
   endtask

   task automatic test_pulse();
      int trig_t;
      eif.evt_ready = 1'b0;
      feed(99);
      n_checks++;
      if (state_o !== S_ARMED) begin
         n_fail++;
         $display("FAIL below_rise: state=%0d, want %0d", state_o, S_ARMED);
      end
      trig_t = t;
      feed(120);
      n_checks++;
      if (state_o !== S_PULSE || baseline_hold !== 1'b1 || eif.evt_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL trigger: state=%0d hold=%b evt_valid=%b, want 3/1/0", state_o, baseline_hold, eif.evt_valid);
      end
      feed(300); feed(200); idle_cyc();
      n_checks++;
      if (state_o !== S_PULSE) begin
         n_fail++;
         $display("FAIL pulse_gap: state=%0d, want %0d", state_o, S_PULSE);
      end
      feed(40);
      n_checks++;
      if (state_o !== S_HOLDOFF || eif.evt_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL pulse_close: state=%0d evt_valid=%b, want 4/1", state_o, eif.evt_valid);
      end
      n_checks++;
      if (eif.evt_peak !== 14'sd300 || eif.evt_width !== 16'd3 || eif.evt_trunc !== 1'b0 || eif.evt_ts !== 32'(trig_t)) begin
         n_fail++;
         $display("FAIL pulse_payload: peak=%0d width=%0d trunc=%b ts=%0d, want 300/3/0/%0d",
                  eif.evt_peak, eif.evt_width, eif.evt_trunc, eif.evt_ts, trig_t);
      end
   endtask

   task automatic test_back_to_back();
      int trig_t;
      feed(0); feed(0); feed(0);
      n_checks++;
      if (state_o !== S_ARMED) begin
         n_fail++;
         $display("FAIL holdoff_done: state=%0d, want %0d", state_o, S_ARMED);
      end
      feed(150); feed(160); feed(10);
      n_checks++;
      if (drop_cnt !== 16'd1 || eif.evt_valid !== 1'b1 || eif.evt_peak !== 14'sd300 || eif.evt_width !== 16'd3) begin
         n_fail++;
         $display("FAIL drop: drop=%0d valid=%b peak=%0d width=%0d, want 1/1/300/3",
                  drop_cnt, eif.evt_valid, eif.evt_peak, eif.evt_width);
      end
      feed(0); feed(0); feed(0);
      trig_t = t;
      feed(200);
      eif.evt_ready = 1'b1;
      feed(20);
      n_checks++;
      if (eif.evt_valid !== 1'b1 || eif.evt_peak !== 14'sd200 || eif.evt_width !== 16'd1 ||
          eif.evt_ts !== 32'(trig_t) || drop_cnt !== 16'd1) begin
         n_fail++;
         $display("FAIL accept_and_post: valid=%b peak=%0d width=%0d ts=%0d drop=%0d, want 1/200/1/%0d/1",
                  eif.evt_valid, eif.evt_peak, eif.evt_width, eif.evt_ts, drop_cnt, trig_t);
      end
      idle_cyc();
      n_checks++;
      if (eif.evt_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL accept_clear: evt_valid=%b, want 0", eif.evt_valid);
      end
   endtask

   task automatic test_trunc();
      feed(0); feed(0); feed(0);
      repeat (7) feed(500);
      n_checks++;
      if (state_o !== S_PULSE) begin
         n_fail++;
         $display("FAIL trunc_open: state=%0d, want %0d", state_o, S_PULSE);
      end
      feed(500);
      n_checks++;
      if (state_o !== S_HOLDOFF || eif.evt_valid !== 1'b1 || eif.evt_width !== 16'd8 ||
          eif.evt_trunc !== 1'b1 || eif.evt_peak !== 14'sd500) begin
         n_fail++;
         $display("FAIL trunc_close: state=%0d valid=%b width=%0d trunc=%b peak=%0d, want 4/1/8/1/500",
                  state_o, eif.evt_valid, eif.evt_width, eif.evt_trunc, eif.evt_peak);
      end
      feed(500); feed(500);
      n_checks++;
      if (state_o !== S_HOLDOFF) begin
         n_fail++;
         $display("FAIL holdoff_notrig: state=%0d, want %0d", state_o, S_HOLDOFF);
      end
      feed(500);
      n_checks++;
      if (state_o !== S_ARMED) begin
         n_fail++;
         $display("FAIL holdoff_exit: state=%0d, want %0d", state_o, S_ARMED);
      end
   endtask

   task automatic test_disable();
      feed(200);
      enable = 1'b0;
      feed(10);
      n_checks++;
      if (state_o !== S_IDLE || filt_rst !== 1'b1 || baseline_hold !== 1'b0 ||
          eif.evt_valid !== 1'b0 || drop_cnt !== 16'd1) begin
         n_fail++;
         $display("FAIL disable: state=%0d filt_rst=%b hold=%b valid=%b drop=%0d, want 0/1/0/0/1",
                  state_o, filt_rst, baseline_hold, eif.evt_valid, drop_cnt);
      end
      idle_cyc(); idle_cyc();
      n_checks++;
      if (eif.evt_valid !== 1'b0 || state_o !== S_IDLE) begin
         n_fail++;
         $display("FAIL disable_noevt: valid=%b state=%0d, want 0/0", eif.evt_valid, state_o);
      end
   endtask

   task automatic test_async_reset();
      start_acq();
      repeat (SETTLE_N) feed(0);
      eif.evt_ready = 1'b0;
      feed(200); feed(10);
      n_checks++;
      if (state_o !== S_HOLDOFF || eif.evt_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL pre_rst: state=%0d valid=%b, want 4/1", state_o, eif.evt_valid);
      end
      #2 rst = 1'b1;
      #1;
      n_checks++;
      if (state_o !== S_IDLE || filt_rst !== 1'b1 || baseline_hold !== 1'b0 || eif.evt_valid !== 1'b0 ||
          drop_cnt !== 16'd0 || eif.evt_peak !== 14'sd0 || eif.evt_width !== 16'd0 || eif.evt_ts !== 32'd0) begin
         n_fail++;
         $display("FAIL async_rst: state=%0d filt_rst=%b hold=%b valid=%b drop=%0d peak=%0d width=%0d ts=%0d, want reset values",
                  state_o, filt_rst, baseline_hold, eif.evt_valid, drop_cnt, eif.evt_peak, eif.evt_width, eif.evt_ts);
      end
      enable = 1'b0;
      @(negedge clk); rst = 1'b0;
   endtask

   task automatic test_random(input int rise, input int fall, input int n);
      int  vld[];
      int  val[];
      ev_t exp_q[$];
      ev_t got_q[$];
      ev_t e;
      int  k, s, h, nmin;
      bit  closed;
      logic [15:0] drop0;
      thr_rise = DATA_W'(rise); thr_fall = DATA_W'(fall);
      eif.evt_ready = 1'b1; enable = 1'b0; sample_valid = 1'b0;
      tick(); tick();
      vld = new[n]; val = new[n];
      for (int i = 0; i < n; i++) begin
         vld[i] = ($urandom_range(0, 9) < 7) ? 1 : 0;
         val[i] = int'($urandom_range(0, 899)) - 300;
      end
      // reference: scan the stream by the sequencing rules
      k = 0; s = 0;
      while (k < n && s < SETTLE_N) begin if (vld[k] != 0) s++; k++; end
      while (k < n) begin
         while (k < n && !(vld[k] != 0 && val[k] >= rise)) k++;
         if (k >= n) break;
         e.ts = k; e.peak = val[k]; e.width = 1; e.trunc = 0; closed = 0; k++;
         while (k < n && !closed) begin
            if (vld[k] != 0) begin
               if (val[k] < fall) closed = 1;
               else begin
                  e.width++;
                  if (val[k] > e.peak) e.peak = val[k];
                  if (e.width == MAX_W) begin closed = 1; e.trunc = 1; end
               end
            end
            k++;
         end
         if (!closed) break;
         exp_q.push_back(e);
         h = 0;
         while (k < n && h < HOLDOFF_N) begin if (vld[k] != 0) h++; k++; end
      end
      drop0 = drop_cnt;
      start_acq();
      for (int i = 0; i < n + 3; i++) begin
         sample_valid = (i < n) ? (vld[i] != 0) : 1'b0;
         filt_in = (i < n) ? DATA_W'(val[i]) : '0;
         tick();
         if (eif.evt_valid === 1'b1) begin
            e.ts = int'(eif.evt_ts); e.peak = int'($signed(eif.evt_peak));
            e.width = int'(eif.evt_width); e.trunc = eif.evt_trunc;
            got_q.push_back(e);
         end
      end
      n_checks++;
      if (got_q.size() != exp_q.size() || drop_cnt !== drop0) begin
         n_fail++;
         $display("FAIL rand_count(%0d,%0d): events=%0d drop=%0d, want %0d/%0d",
                  rise, fall, got_q.size(), drop_cnt, exp_q.size(), drop0);
      end
      nmin = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < nmin; i++) begin
         n_checks++;
         if (got_q[i].ts != exp_q[i].ts || got_q[i].peak != exp_q[i].peak ||
             got_q[i].width != exp_q[i].width || got_q[i].trunc != exp_q[i].trunc) begin
            n_fail++;
            $display("FAIL rand_evt%0d(%0d,%0d): ts=%0d peak=%0d width=%0d trunc=%0d, want %0d/%0d/%0d/%0d",
                     i, rise, fall, got_q[i].ts, got_q[i].peak, got_q[i].width, got_q[i].trunc,
                     exp_q[i].ts, exp_q[i].peak, exp_q[i].width, exp_q[i].trunc);
         end
      end
   endtask

   initial begin
      eif.evt_ready = 1'b0;
      test_reset();
      test_settle();
      test_pulse();
      test_back_to_back();
      test_trunc();
      test_disable();
      test_async_reset();
      test_random(100, 50, 300);
      test_random(200, 300, 300);
      test_random(0, -100, 300);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
